// File: rtl/fetch_pc_stage.sv
// Fetch stage of the pipelined RV32I core.
// It holds the program counter and picks the next PC from the execute-stage
// redirect, the hazard-unit stall, or sequential PC+4.
// It also holds the IF/ID pipeline register.
// Optional build macro: FETCH_REDIRECT_CNT_EN adds a saturating counter of
// taken redirects on RedirectCnt. Without the macro that port is tied to zero.
module fetch_pc_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic [31:0]           RedirectCnt
);

    localparam logic [DATA_WIDTH-1:0] PC_INC   = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ZERO_VAL = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  kill_decode;

    // Sequential successor; wraps silently at the top of the address space
    assign PCPlus4F    = PCF + PC_INC;
    // Instruction fetch is word aligned, so the low two target bits are dropped
    assign redirect_pc = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
    // A taken redirect squashes the wrong-path instruction held in IF/ID
    assign kill_decode = FlushD | PCSrcE;

    // Next-PC select: a redirect wins over a stall, so a taken branch is not lost
    always_comb begin
        pc_next = PCPlus4F;
        if (PCSrcE) begin
            pc_next = redirect_pc;
        end else if (StallF) begin
            pc_next = PCF;
        end else begin
            pc_next = PCPlus4F;
        end
    end

    // Program counter register; PCF is driven only by this register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= pc_next;
        end
    end

    // IF/ID register: flush beats stall, otherwise capture the fetched word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= ZERO_VAL;
            PCPlus4D <= ZERO_VAL;
            ValidD   <= 1'b0;
        end else if (kill_decode) begin
            InstrD   <= NOP_INSTR;
            PCD      <= ZERO_VAL;
            PCPlus4D <= ZERO_VAL;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCD      <= PCD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            ValidD   <= 1'b1;
        end
    end

`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt;

    // Saturating count of taken redirects, stalled cycles included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt <= 32'h0000_0000;
        end else if (PCSrcE && (redirect_cnt != 32'hFFFF_FFFF)) begin
            redirect_cnt <= redirect_cnt + 32'h0000_0001;
        end else begin
            redirect_cnt <= redirect_cnt;
        end
    end

    assign RedirectCnt = redirect_cnt;
`else
    assign RedirectCnt = 32'h0000_0000;
`endif

endmodule
